// File: rtl/hex_display_driver.sv
// Multi-digit registered hex -> 7-segment driver. It converts one digit per cycle into a shadow
// image, commits the image atomically, and adds leading-zero blanking, "Err" and blink.
// Optional macro HEX_DISPLAY_SIGNED_EN: VALUE is two's complement and shown with a minus glyph.
module hex_display_driver #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int LZ_BLANK  = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  ERROR,
  input  logic                  BLINK,
  output logic                  READY,
  output logic                  DONE,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(BLINK_DIV + 1);

  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_R     = 7'h2F;
  localparam logic [6:0] G_MINUS = 7'h3F;
  localparam logic [6:0] G_OFF   = 7'h7F;

  if (DIGITS < 3) begin : g_bad_digits
    $error("hex_display_driver: DIGITS must be >= 3");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("hex_display_driver: BLINK_DIV must be >= 1");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [W-1:0]       val_reg, val_next;
  logic               err_reg, err_next;
  logic               seen_reg, seen_next;
  logic               done_reg;
  logic               commit;
  logic               capture;
  logic [6:0]         glyph;
  logic [6:0]         shadow_reg [DIGITS];
  logic [6:0]         disp_reg [DIGITS];
  logic [CNT_W-1:0]   cnt_reg;
  logic               phase_on_reg;

  logic [W-1:0]       cap_value;
  logic               cap_err;
  logic               neg_reg;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h18;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign capture = (state_reg == IDLE) && LOAD;

`ifdef HEX_DISPLAY_SIGNED_EN
  // A negative value needs an empty top digit to hold the minus, otherwise it cannot be shown.
  logic cap_neg;
  assign cap_neg   = VALUE[W-1];
  assign cap_value = cap_neg ? (~VALUE + 1'b1) : VALUE;
  assign cap_err   = ERROR | (cap_neg & (cap_value[W-1 -: 4] != 4'd0));

  always_ff @(posedge CLOCK_50) begin
    if (RESET)
      neg_reg <= 1'b0;
    else if (capture)
      neg_reg <= cap_neg;
  end
`else
  assign cap_value = VALUE;
  assign cap_err   = ERROR;
  assign neg_reg   = 1'b0;
`endif

  // Glyph for the digit being converted this cycle.
  logic [3:0]       nib, nib_lo;
  logic [IDX_W-1:0] idx_lo;
  logic             lead_zero, lo_shown;

  always_comb begin
    idx_lo    = idx_reg - 1'b1;
    nib       = val_reg[{idx_reg, 2'b00} +: 4];
    nib_lo    = (idx_reg != '0) ? val_reg[{idx_lo, 2'b00} +: 4] : 4'd0;
    lead_zero = (LZ_BLANK != 0) && !seen_reg && (nib == 4'd0) && (idx_reg != '0);
    lo_shown  = (idx_reg == IDX_W'(1)) || (nib_lo != 4'd0);
    glyph     = hex_glyph(nib);
    if (err_reg) begin
      if (idx_reg == IDX_W'(2))
        glyph = G_E;
      else if (idx_reg < IDX_W'(2))
        glyph = G_R;
      else
        glyph = G_OFF;
    end else if (neg_reg && (LZ_BLANK == 0) && (idx_reg == IDX_W'(DIGITS - 1))) begin
      glyph = G_MINUS;
    end else if (lead_zero) begin
      glyph = (neg_reg && lo_shown) ? G_MINUS : G_OFF;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    val_next   = val_reg;
    err_next   = err_reg;
    seen_next  = seen_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (LOAD) begin
          state_next = CONV;
          idx_next   = IDX_W'(DIGITS - 1);
          val_next   = cap_value;
          err_next   = cap_err;
          seen_next  = 1'b0;
        end
      end
      CONV: begin
        seen_next = seen_reg | (nib != 4'd0);
        idx_next  = idx_reg - 1'b1;
        if (idx_reg == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      val_reg   <= '0;
      err_reg   <= 1'b0;
      seen_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      val_reg   <= val_next;
      err_reg   <= err_next;
      seen_reg  <= seen_next;
      done_reg  <= commit;
    end
  end

  // Blink timebase runs free, independent of the conversion FSM.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_reg      <= '0;
      phase_on_reg <= 1'b1;
    end else if (cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
      cnt_reg      <= '0;
      phase_on_reg <= ~phase_on_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Digit 0 is committed straight from the glyph path, since it is written in the commit cycle.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    always_ff @(posedge CLOCK_50) begin
      if ((state_reg == CONV) && (idx_reg == IDX_W'(gi)))
        shadow_reg[gi] <= glyph;
    end

    always_ff @(posedge CLOCK_50) begin
      if (RESET)
        disp_reg[gi] <= G_OFF;
      else if (commit)
        disp_reg[gi] <= (gi == 0) ? glyph : shadow_reg[gi];
    end

    assign HEX[7*gi +: 7] = (BLINK && !phase_on_reg) ? G_OFF : disp_reg[gi];
  end

  assign READY = (state_reg == IDLE);
  assign DONE  = done_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver: table of vectors through a scoreboard queue,
// plus hand-written sequences for latency, ignored loads, blink and mid-conversion reset.
module tb_hex_display_driver;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        err;
  logic        blink;
  logic [15:0] value;
  logic        ready, done, ready0, done0;
  logic [27:0] hex, hex0;

  always #5 clk = ~clk;

  hex_display_driver #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV), .LZ_BLANK(1)) dut (
    .CLOCK_50(clk), .RESET(rst), .LOAD(load), .VALUE(value), .ERROR(err), .BLINK(blink),
    .READY(ready), .DONE(done), .HEX(hex)
  );

  hex_display_driver #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV), .LZ_BLANK(0)) dut_lz0 (
    .CLOCK_50(clk), .RESET(rst), .LOAD(load), .VALUE(value), .ERROR(err), .BLINK(blink),
    .READY(ready0), .DONE(done0), .HEX(hex0)
  );

  // Reference blink timebase.
  int   m_cnt;
  logic m_on;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_on  <= 1'b1;
    end else if (m_cnt == BLINK_DIV - 1) begin
      m_cnt <= 0;
      m_on  <= ~m_on;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct {
    logic [15:0] value;
    logic        error;
    logic [27:0] exp1;
    logic [27:0] exp0;
  } vec_t;

  typedef struct {
    logic [27:0] exp1;
    logic [27:0] exp0;
    int          id;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

  function automatic logic [27:0] p4(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one LOAD, pushes the expectation, then waits (bounded) for DONE and scores it.
  task automatic run_load(input logic [15:0] v, input logic e, input logic [27:0] x1,
                          input logic [27:0] x0, input int id);
    int  k;
    sb_t s;
    k = 0;
    while (!ready && k < 20) begin
      step();
      k++;
    end
    check($sformatf("ready_before_load[%0d]", id), 28'(ready), 28'd1);
    value = v;
    err   = e;
    load  = 1'b1;
    sb_q.push_back('{x1, x0, id});
    step();
    load = 1'b0;
    k = 1;
    while (!done && k < 12) begin
      step();
      k++;
    end
    check($sformatf("latency[%0d]", id), 28'(k), 28'(DIGITS + 1));
    s = sb_q.pop_front();
    if (done) begin
      check($sformatf("hex_lz1[%0d]", s.id), hex, s.exp1);
      check($sformatf("hex_lz0[%0d]", s.id), hex0, s.exp0);
      check($sformatf("done_lz0[%0d]", s.id), 28'(done0), 28'd1);
    end else begin
      check($sformatf("done_seen[%0d]", s.id), 28'(done), 28'd1);
    end
    step();
  endtask

  initial begin
    int          n_on, n_off, saw_done;
    logic [27:0] img;

    vecs[0] = '{16'h00A3, 1'b0, p4(7'h7F, 7'h7F, 7'h08, 7'h30), p4(7'h40, 7'h40, 7'h08, 7'h30)};
    vecs[1] = '{16'h0000, 1'b0, p4(7'h7F, 7'h7F, 7'h7F, 7'h40), p4(7'h40, 7'h40, 7'h40, 7'h40)};
    vecs[2] = '{16'h1234, 1'b0, p4(7'h79, 7'h24, 7'h30, 7'h19), p4(7'h79, 7'h24, 7'h30, 7'h19)};
    vecs[3] = '{16'h0010, 1'b0, p4(7'h7F, 7'h7F, 7'h79, 7'h40), p4(7'h40, 7'h40, 7'h79, 7'h40)};
    vecs[4] = '{16'h1234, 1'b1, p4(7'h7F, 7'h06, 7'h2F, 7'h2F), p4(7'h7F, 7'h06, 7'h2F, 7'h2F)};
`ifdef HEX_DISPLAY_SIGNED_EN
    vecs[5] = '{16'hFFFE, 1'b0, p4(7'h7F, 7'h7F, 7'h3F, 7'h24), p4(7'h3F, 7'h40, 7'h40, 7'h24)};
    vecs[6] = '{16'h8000, 1'b0, p4(7'h7F, 7'h06, 7'h2F, 7'h2F), p4(7'h7F, 7'h06, 7'h2F, 7'h2F)};
    vecs[7] = '{16'hF00F, 1'b0, p4(7'h3F, 7'h0E, 7'h0E, 7'h79), p4(7'h3F, 7'h0E, 7'h0E, 7'h79)};
    vecs[8] = '{16'hC0DE, 1'b0, p4(7'h7F, 7'h06, 7'h2F, 7'h2F), p4(7'h7F, 7'h06, 7'h2F, 7'h2F)};
`else
    vecs[5] = '{16'hFFFE, 1'b0, p4(7'h0E, 7'h0E, 7'h0E, 7'h06), p4(7'h0E, 7'h0E, 7'h0E, 7'h06)};
    vecs[6] = '{16'h8000, 1'b0, p4(7'h00, 7'h40, 7'h40, 7'h40), p4(7'h00, 7'h40, 7'h40, 7'h40)};
    vecs[7] = '{16'hF00F, 1'b0, p4(7'h0E, 7'h40, 7'h40, 7'h0E), p4(7'h0E, 7'h40, 7'h40, 7'h0E)};
    vecs[8] = '{16'hC0DE, 1'b0, p4(7'h46, 7'h40, 7'h21, 7'h06), p4(7'h46, 7'h40, 7'h21, 7'h06)};
`endif

    rst = 1'b1; load = 1'b0; err = 1'b0; blink = 1'b0; value = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state, then idle with LOAD low.
    check("reset_hex", hex, ALL_OFF);
    check("reset_ready", 28'(ready), 28'd1);
    check("reset_done", 28'(done), 28'd0);
    repeat (3) step();
    check("idle_hex", hex, ALL_OFF);
    check("idle_done", 28'(done), 28'd0);

    // 00A3 with a second LOAD in cycle 2 that must be ignored, then a LOAD in the DONE cycle.
    value = 16'h00A3; load = 1'b1;
    step();
    load = 1'b0;
    check("busy_c1", 28'(ready), 28'd0);
    step();
    check("busy_c2", 28'(ready), 28'd0);
    value = 16'h1111; load = 1'b1;
    step();
    load = 1'b0; value = 16'h00A3;
    check("busy_c3", 28'(ready), 28'd0);
    check("no_early_hex", hex, ALL_OFF);
    step();
    check("busy_c4", 28'(ready), 28'd0);
    check("no_done_c4", 28'(done), 28'd0);
    step();
    check("done_c5", 28'(done), 28'd1);
    check("ready_c5", 28'(ready), 28'd1);
    check("hex_00A3", hex, p4(7'h7F, 7'h7F, 7'h08, 7'h30));
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    check("done_pulse_width", 28'(done), 28'd0);
    check("load_in_done_cycle", 28'(ready), 28'd0);
    repeat (4) step();
    check("done_second", 28'(done), 28'd1);
    check("hex_second", hex, p4(7'h79, 7'h24, 7'h30, 7'h19));
    saw_done = 0;
    repeat (6) begin
      step();
      if (done) saw_done++;
    end
    check("no_queued_load", 28'(saw_done), 28'd0);

    // Table of vectors through the scoreboard.
    for (int i = 0; i < 9; i++)
      run_load(vecs[i].value, vecs[i].error, vecs[i].exp1, vecs[i].exp0, i);
    check("scoreboard_empty", 28'(sb_q.size()), 28'd0);

    // Blink after a commit of 1234.
    run_load(16'h1234, 1'b0, vecs[2].exp1, vecs[2].exp0, 100);
    img = p4(7'h79, 7'h24, 7'h30, 7'h19);
    blink = 1'b1;
    n_on = 0; n_off = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("blink[%0d]", c), hex, m_on ? img : ALL_OFF);
      if (m_on) n_on++; else n_off++;
      check($sformatf("blink_ready[%0d]", c), 28'(ready), 28'd1);
    end
    check("blink_saw_off", 28'(n_off != 0), 28'd1);
    check("blink_saw_on", 28'(n_on != 0), 28'd1);
    blink = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("steady[%0d]", c), hex, img);
    end

    // Reset during cycle 2 of a conversion.
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_hex", hex, ALL_OFF);
    check("rst_mid_ready", 28'(ready), 28'd1);
    check("rst_mid_done", 28'(done), 28'd0);
    saw_done = 0;
    repeat (8) begin
      step();
      if (done) saw_done++;
    end
    check("rst_mid_no_done", 28'(saw_done), 28'd0);
    check("rst_mid_hex_after", hex, ALL_OFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
